uart_rx_control: RTL and testbench
==================================

// Module: uart_rx_control
// PURPOSE
//  Receive side of the UART link: 1 start, 8 data (LSB first), 1 stop, no parity, idle high.
//  Synchronises RX_Pin_In and detects the start bit. An internal baud counter samples each bit at mid-bit.
//  Presents the assembled byte with a 1-cycle done strobe and flags framing errors.
//  Sits between the board RX pin and the host logic, mirroring the TX control path.
// PARAMETERS
//  BPS_DIV   434  CLK cycles per bit (e.g. 50 MHz / 115200); must be >= 8
//  HALF_DIV  BPS_DIV/2  cycles from start-edge detect to the start-bit mid sample
// PORTS
//  CLK          in   1  system clock, all logic on posedge
//  RSTn         in   1  asynchronous, active-low reset
//  RX_En_Sig    in   1  receive enable; 0 holds/forces IDLE
//  RX_Pin_In    in   1  asynchronous serial input, idle high
//  RX_Data      out  8  last good byte; valid when RX_Done_Sig=1, held until next good byte
//  RX_Done_Sig  out  1  1-cycle pulse: byte received with valid stop bit
//  RX_Err_Sig   out  1  1-cycle pulse: stop bit sampled low (framing error)
//  RX_Busy      out  1  1 while the FSM is not in IDLE
// BEHAVIOUR
//  Reset: RX_Data=8'h00, RX_Done_Sig=0, RX_Err_Sig=0, RX_Busy=0, FSM=IDLE, sync flops=1, counters=0.
//  Input path: 2-flop synchroniser (reset 1) plus 1 history flop. A start edge is prev=1 & cur=0 on synced data.
//  Baud counter cnt: cleared on entering START, DATA or STOP. Increments each CLK. "tick" when cnt==limit-1.
//  FSM states:
//   IDLE : RX_En_Sig & start edge -> START, cnt=0.
//   START: tick at HALF_DIV; synced RX=0 -> DATA, bit_idx=0. RX=1 -> IDLE (glitch reject, no pulses).
//   DATA : tick at BPS_DIV; shift[bit_idx]<=synced RX. bit_idx==7 -> STOP, else bit_idx+1.
//   STOP : tick at BPS_DIV; RX=1 -> RX_Data<=shift, RX_Done_Sig=1 for 1 cycle, -> IDLE.
//          RX=0 -> RX_Err_Sig=1 for 1 cycle, RX_Data unchanged, -> BREAK.
//   BREAK: wait until synced RX=1, then -> IDLE. Covers a line held low or break, with no false restarts.
//  Latency: RX_Done_Sig rises 2 sync cycles + HALF_DIV + 9*BPS_DIV cycles after the pin falling edge (+/-1).
//  All samples are at mid-bit. The next start edge is accepted the cycle after return to IDLE, so back-to-back frames work.
//  RX_En_Sig=0 in any state: next cycle FSM=IDLE, cnt/bit_idx cleared, no pulse, RX_Data held.
//  Reset mid-frame: everything returns to reset values immediately; the partial byte is discarded.
//  RX_Done_Sig and RX_Err_Sig are never both 1. Neither is asserted outside the STOP->exit cycle.
//  Width rules: cnt is $clog2(BPS_DIV) bits, bit_idx is 3 bits. No wrap: cnt is cleared on every tick.
// STRUCTURE
//  Shared package uart_pkg: state encodings (IDLE, START, DATA, STOP, BREAK), DATA_BITS=8, default BPS_DIV.
//  Same BPS_DIV as TX so both ends agree.
//  One sub-module: uart_rx_bps (counter with clr/en/limit select -> tick). Synchroniser and FSM stay in the top.
// TESTING  (bench uses BPS_DIV=16, HALF_DIV=8)
//  1 Frame 0x55 with stop=1 -> RX_Done_Sig 1 cycle, RX_Data=8'h55, RX_Err_Sig=0, RX_Busy 1->0.
//  2 Back-to-back 0xA5,0x3C, no idle gap -> two done pulses, RX_Data 8'hA5 then 8'h3C.
//  3 Low glitch of 4 cycles on idle line -> FSM returns to IDLE, no pulses, RX_Data unchanged.
//  4 Frame 0xFF with stop=0, line low 40 cycles then high -> RX_Err_Sig 1 pulse.
//    RX_Data unchanged, stays in BREAK until high; next frame 0x81 received OK.
//  5 Reset asserted mid-DATA (bit 4 of 0x0F) -> outputs at reset values; next 0x0F decodes correctly.
//  6 RX_En_Sig dropped mid-frame then raised during idle -> no pulse; next frame 0x12 -> RX_Data=8'h12.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame size, default baud divider and receiver state encodings.
// The TX side uses the same BPS_DIV_DEFAULT so both ends of the link agree on bit timing.
package uart_pkg;

  localparam int DATA_BITS       = 8;
  localparam int BPS_DIV_DEFAULT = 434;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_bps.sv
// Receive baud counter: counts CLK cycles and ticks at the end of a half or full bit period.
// The count restarts on every tick, so it never wraps.
module uart_rx_bps
  import uart_pkg::*;
#(
  parameter int BPS_DIV  = BPS_DIV_DEFAULT,
  parameter int HALF_DIV = BPS_DIV / 2
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  input  logic en,
  input  logic half_sel,
  output logic tick
);

  localparam int CW = $clog2(BPS_DIV);
  localparam logic [CW-1:0] FULL_LAST = CW'(BPS_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == (half_sel ? HALF_LAST : FULL_LAST));
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_control.sv
// UART receiver: 8N1, LSB first, idle high. Synchronises the pin, samples each bit at mid-bit
// and reports each frame with a one-cycle done (good stop bit) or error (stop bit low) pulse.
module uart_rx_control
  import uart_pkg::*;
#(
  parameter int BPS_DIV  = BPS_DIV_DEFAULT,
  parameter int HALF_DIV = BPS_DIV / 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       RX_En_Sig,
  input  logic       RX_Pin_In,
  output logic [7:0] RX_Data,
  output logic       RX_Done_Sig,
  output logic       RX_Err_Sig,
  output logic       RX_Busy
);

  logic sync1_q, sync2_q, prev_q;
  logic rx_s, start_edge;

  logic [2:0]           state_q, state_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic bps_clr, bps_en, half_sel, tick;

  // Sync flops reset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= RX_Pin_In;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s       = sync2_q;
  assign start_edge = prev_q & ~sync2_q;

  uart_rx_bps #(
    .BPS_DIV (BPS_DIV),
    .HALF_DIV(HALF_DIV)
  ) u_bps (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clr     (bps_clr),
    .en      (bps_en),
    .half_sel(half_sel),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    bps_clr   = 1'b0;
    bps_en    = 1'b0;
    half_sel  = 1'b0;
    if (!RX_En_Sig) begin
      state_d   = ST_IDLE;
      bit_idx_d = '0;
      bps_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bps_clr = 1'b1;
          if (start_edge) state_d = ST_START;
        end
        ST_START: begin
          bps_en   = 1'b1;
          half_sel = 1'b1;
          if (tick) begin
            if (!rx_s) begin
              state_d   = ST_DATA;
              bit_idx_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          bps_en = 1'b1;
          if (tick) begin
            shift_d[bit_idx_q] = rx_s;
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
              state_d = ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
        ST_STOP: begin
          bps_en = 1'b1;
          if (tick) begin
            if (rx_s) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_BREAK;
            end
          end
        end
        // A line held low after a bad stop bit must go high before a new start edge counts.
        ST_BREAK: begin
          bps_clr = 1'b1;
          if (rx_s) state_d = ST_IDLE;
        end
        default: begin
          bps_clr = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign RX_Data     = data_q;
  assign RX_Done_Sig = done_q;
  assign RX_Err_Sig  = err_q;
  assign RX_Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_control.sv
// Self-checking bench for uart_rx_control: drives serial frames on the pin and compares the
// reported bytes, pulses and busy flag against a frame-level model of the receiver.
module tb_uart_rx_control;

  localparam int BPS  = 16;
  localparam int HALF = 8;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       RX_En_Sig = 1'b1;
  logic       RX_Pin_In = 1'b1;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig;
  logic       RX_Err_Sig;
  logic       RX_Busy;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int fall_cyc = 0;
  logic busy_mid = 1'b0;
  logic [7:0] model_data = 8'h00;

  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [7:0] done_log [256];
  int done_cyc_log [256];

  uart_rx_control #(
    .BPS_DIV (BPS),
    .HALF_DIV(HALF)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .RX_En_Sig  (RX_En_Sig),
    .RX_Pin_In  (RX_Pin_In),
    .RX_Data    (RX_Data),
    .RX_Done_Sig(RX_Done_Sig),
    .RX_Err_Sig (RX_Err_Sig),
    .RX_Busy    (RX_Busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Log every output pulse; a stretched pulse shows up as an extra count.
  always @(negedge CLK) begin
    if (RX_Done_Sig) begin
      done_log[done_cnt & 255]     <= RX_Data;
      done_cyc_log[done_cnt & 255] <= cyc;
      done_cnt <= done_cnt + 1;
    end
    if (RX_Err_Sig) err_cnt <= err_cnt + 1;
    if (RX_Done_Sig && RX_Err_Sig) both_cnt <= both_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    RX_Pin_In = 1'b0;
    fall_cyc  = cyc;
    idle(BPS);
    busy_mid = RX_Busy;
    for (int i = 0; i < 8; i++) begin
      RX_Pin_In = b[i];
      idle(BPS);
    end
    RX_Pin_In = stop;
    idle(BPS);
    RX_Pin_In = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    idle(3);
    checks++; if (RX_Data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got=%h exp=00", RX_Data); end
    checks++; if (RX_Done_Sig !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", RX_Done_Sig); end
    checks++; if (RX_Err_Sig !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", RX_Err_Sig); end
    checks++; if (RX_Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", RX_Busy); end
    RSTn = 1'b1;
    idle(5);
  endtask

  task automatic test_single_frame();
    int base = done_cnt;
    int ebase = err_cnt;
    int lat;
    send_frame(8'h55, 1'b1);
    model_data = 8'h55;
    idle(4);
    lat = done_cyc_log[base & 255] - fall_cyc;
    checks++; if (done_cnt - base !== 1) begin errors++; $display("[TB] FAIL single_done_count got=%0d exp=1", done_cnt - base); end
    checks++; if (done_log[base & 255] !== model_data) begin errors++; $display("[TB] FAIL single_byte got=%h exp=%h", done_log[base & 255], model_data); end
    checks++; if (err_cnt - ebase !== 0) begin errors++; $display("[TB] FAIL single_err_count got=%0d exp=0", err_cnt - ebase); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_mid got=%b exp=1", busy_mid); end
    checks++; if (RX_Busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end got=%b exp=0", RX_Busy); end
    checks++; if (RX_Data !== model_data) begin errors++; $display("[TB] FAIL single_data_held got=%h exp=%h", RX_Data, model_data); end
    checks++; if (lat < 2 + HALF + 9 * BPS - 1 || lat > 2 + HALF + 9 * BPS + 1) begin
      errors++; $display("[TB] FAIL single_latency got=%0d exp=%0d+/-1", lat, 2 + HALF + 9 * BPS);
    end
  endtask

  task automatic test_back_to_back();
    int base = done_cnt;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    model_data = 8'h3C;
    idle(4);
    checks++; if (done_cnt - base !== 2) begin errors++; $display("[TB] FAIL b2b_done_count got=%0d exp=2", done_cnt - base); end
    checks++; if (done_log[base & 255] !== 8'hA5) begin errors++; $display("[TB] FAIL b2b_first got=%h exp=a5", done_log[base & 255]); end
    checks++; if (done_log[(base + 1) & 255] !== 8'h3C) begin errors++; $display("[TB] FAIL b2b_second got=%h exp=3c", done_log[(base + 1) & 255]); end
  endtask

  task automatic test_glitch();
    int base = done_cnt;
    int ebase = err_cnt;
    RX_Pin_In = 1'b0;
    idle(4);
    busy_mid = RX_Busy;
    RX_Pin_In = 1'b1;
    idle(30);
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_start got=%b exp=1", busy_mid); end
    checks++; if (RX_Busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_end got=%b exp=0", RX_Busy); end
    checks++; if (done_cnt - base !== 0 || err_cnt - ebase !== 0) begin
      errors++; $display("[TB] FAIL glitch_pulses done=%0d err=%0d exp=0,0", done_cnt - base, err_cnt - ebase);
    end
    checks++; if (RX_Data !== model_data) begin errors++; $display("[TB] FAIL glitch_data got=%h exp=%h", RX_Data, model_data); end
  endtask

  task automatic test_break();
    int base = done_cnt;
    int ebase = err_cnt;
    send_frame(8'hFF, 1'b0);
    RX_Pin_In = 1'b0;
    idle(40 - BPS);
    checks++; if (err_cnt - ebase !== 1) begin errors++; $display("[TB] FAIL break_err_count got=%0d exp=1", err_cnt - ebase); end
    checks++; if (done_cnt - base !== 0) begin errors++; $display("[TB] FAIL break_done_count got=%0d exp=0", done_cnt - base); end
    checks++; if (RX_Busy !== 1'b1) begin errors++; $display("[TB] FAIL break_busy_low got=%b exp=1", RX_Busy); end
    checks++; if (RX_Data !== model_data) begin errors++; $display("[TB] FAIL break_data got=%h exp=%h", RX_Data, model_data); end
    RX_Pin_In = 1'b1;
    idle(6);
    checks++; if (RX_Busy !== 1'b0) begin errors++; $display("[TB] FAIL break_busy_high got=%b exp=0", RX_Busy); end
    send_frame(8'h81, 1'b1);
    model_data = 8'h81;
    idle(4);
    checks++; if (done_cnt - base !== 1) begin errors++; $display("[TB] FAIL break_next_count got=%0d exp=1", done_cnt - base); end
    checks++; if (RX_Data !== model_data) begin errors++; $display("[TB] FAIL break_next_data got=%h exp=%h", RX_Data, model_data); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    logic [7:0] b = 8'h0F;
    RX_Pin_In = 1'b0;
    idle(BPS);
    for (int i = 0; i < 4; i++) begin
      RX_Pin_In = b[i];
      idle(BPS);
    end
    RX_Pin_In = b[4];
    idle(HALF);
    RSTn = 1'b0;
    model_data = 8'h00;
    #1;
    checks++; if (RX_Data !== model_data) begin errors++; $display("[TB] FAIL midreset_data got=%h exp=%h", RX_Data, model_data); end
    checks++; if (RX_Busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got=%b exp=0", RX_Busy); end
    RX_Pin_In = 1'b1;
    idle(3);
    RSTn = 1'b1;
    idle(5);
    base = done_cnt;
    send_frame(8'h0F, 1'b1);
    model_data = 8'h0F;
    idle(4);
    checks++; if (done_cnt - base !== 1) begin errors++; $display("[TB] FAIL midreset_next_count got=%0d exp=1", done_cnt - base); end
    checks++; if (RX_Data !== model_data) begin errors++; $display("[TB] FAIL midreset_next_data got=%h exp=%h", RX_Data, model_data); end
  endtask

  task automatic test_enable();
    int base = done_cnt;
    int ebase = err_cnt;
    logic [7:0] b = 8'hC3;
    RX_Pin_In = 1'b0;
    idle(BPS);
    RX_Pin_In = b[0];
    idle(BPS + HALF);
    checks++; if (RX_Busy !== 1'b1) begin errors++; $display("[TB] FAIL enable_busy_before got=%b exp=1", RX_Busy); end
    RX_En_Sig = 1'b0;
    idle(2);
    checks++; if (RX_Busy !== 1'b0) begin errors++; $display("[TB] FAIL enable_busy_dropped got=%b exp=0", RX_Busy); end
    for (int i = 1; i < 8; i++) begin
      RX_Pin_In = b[i];
      idle(BPS);
    end
    RX_Pin_In = 1'b1;
    idle(BPS + 10);
    RX_En_Sig = 1'b1;
    idle(10);
    checks++; if (done_cnt - base !== 0 || err_cnt - ebase !== 0) begin
      errors++; $display("[TB] FAIL enable_pulses done=%0d err=%0d exp=0,0", done_cnt - base, err_cnt - ebase);
    end
    checks++; if (RX_Data !== model_data) begin errors++; $display("[TB] FAIL enable_data got=%h exp=%h", RX_Data, model_data); end
    send_frame(8'h12, 1'b1);
    model_data = 8'h12;
    idle(4);
    checks++; if (done_cnt - base !== 1) begin errors++; $display("[TB] FAIL enable_next_count got=%0d exp=1", done_cnt - base); end
    checks++; if (RX_Data !== model_data) begin errors++; $display("[TB] FAIL enable_next_data got=%h exp=%h", RX_Data, model_data); end
  endtask

  task automatic test_random_frames();
    int base = done_cnt;
    int ebase = err_cnt;
    int exp_bad = 0;
    logic [7:0] exp_q[$];
    for (int n = 0; n < 10; n++) begin
      logic [7:0] b = 8'($urandom);
      logic stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      if (stop) begin
        exp_q.push_back(b);
        model_data = b;
      end else begin
        exp_bad++;
      end
      idle(stop ? $urandom_range(0, 20) : $urandom_range(4, 20));
    end
    idle(5);
    checks++; if (done_cnt - base !== exp_q.size()) begin errors++; $display("[TB] FAIL rand_done_count got=%0d exp=%0d", done_cnt - base, exp_q.size()); end
    checks++; if (err_cnt - ebase !== exp_bad) begin errors++; $display("[TB] FAIL rand_err_count got=%0d exp=%0d", err_cnt - ebase, exp_bad); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++; if (done_log[(base + k) & 255] !== exp_q[k]) begin
        errors++; $display("[TB] FAIL rand_byte_%0d got=%h exp=%h", k, done_log[(base + k) & 255], exp_q[k]);
      end
    end
    checks++; if (RX_Data !== model_data) begin errors++; $display("[TB] FAIL rand_data_held got=%h exp=%h", RX_Data, model_data); end
    checks++; if (both_cnt !== 0) begin errors++; $display("[TB] FAIL done_err_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_enable();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
